// File: rtl/fourbit_pkg.sv
// rtl/fourbit_pkg.sv - shared opcodes, state encoding and helpers for the 4-bit sequencer
package fourbit_pkg;

  localparam int ACC_SEL_W = 2;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_NOPB = 4'hB;
  localparam logic [3:0] OP_NOPC = 4'hC;
  localparam logic [3:0] OP_NOPD = 4'hD;
  localparam logic [3:0] OP_RETI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    PC_INC,
    PC_JUMP,
    PC_RETI,
    PC_HOLD
  } pc_mode_t;

  // LDI through MOV are the only opcodes that write an accumulator.
  function automatic logic writes_acc(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/fourbit_pc_unit.sv
// rtl/fourbit_pc_unit.sv - program counter with increment/wrap, jump load and ISR shadow
module fourbit_pc_unit
  import fourbit_pkg::*;
#(
  parameter logic [3:0] IRQ_VECTOR = 4'hC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  pc_mode_t   mode,
  input  logic [3:0] jump_target,
  input  logic       irq_take,
  output logic [3:0] pc,
  output logic [3:0] shadow_pc
);

  logic [3:0] pc_q, pc_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] next_pc;

  always_comb begin
    unique case (mode)
      PC_JUMP: next_pc = jump_target;
      PC_RETI: next_pc = shadow_q;
      PC_HOLD: next_pc = pc_q;
      default: next_pc = pc_q + 4'd1;
    endcase

    pc_d     = pc_q;
    shadow_d = shadow_q;
    // On interrupt entry the address this step would have produced becomes the return point.
    if (step_en) begin
      if (irq_take) begin
        shadow_d = next_pc;
        pc_d     = IRQ_VECTOR;
      end else begin
        pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= 4'h0;
      shadow_q <= 4'h0;
    end else begin
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
    end
  end

  assign pc        = pc_q;
  assign shadow_pc = shadow_q;

endmodule

// File: rtl/fourbit_sequencer.sv
// rtl/fourbit_sequencer.sv - fetch/decode/execute/writeback control FSM with one interrupt level and HALT
module fourbit_sequencer
  import fourbit_pkg::*;
#(
  parameter logic [3:0] IRQ_VECTOR = 4'hC,
  parameter logic [3:0] HALT_OP    = OP_HALT,
  parameter logic [3:0] RETI_OP    = OP_RETI
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [3:0]           opcode,
  input  logic [3:0]           operand,
  input  logic                 flag_z,
  input  logic                 flag_c,
  input  logic                 irq,
  output logic                 irq_ack,
  output logic [3:0]           pc,
  output logic [3:0]           ir,
  output logic [3:0]           alu_op,
  output logic [ACC_SEL_W-1:0] dst_sel,
  output logic [ACC_SEL_W-1:0] src_sel,
  output logic [3:0]           imm,
  output logic                 acc_we,
  output logic                 in_isr,
  output logic                 halted
);

  state_t                 state_q, state_d;
  logic [3:0]             ir_q, ir_d;
  logic [3:0]             imm_q, imm_d;
  logic [3:0]             alu_op_q, alu_op_d;
  logic [ACC_SEL_W-1:0]   dst_q, dst_d;
  logic [ACC_SEL_W-1:0]   src_q, src_d;
  logic                   take_q, take_d;
  logic                   in_isr_q, in_isr_d;

  logic                   irq_take;
  logic                   pc_step;
  logic                   pc_irq;
  pc_mode_t               pc_mode;
  logic [3:0]             shadow_pc;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    dst_d       = dst_q;
    src_d       = src_q;
    take_d      = take_q;
    in_isr_d    = in_isr_q;
    instr_ready = 1'b0;
    acc_we      = 1'b0;
    irq_ack     = 1'b0;
    pc_step     = 1'b0;
    pc_irq      = 1'b0;
    pc_mode     = PC_INC;
    irq_take    = irq && !in_isr_q;

    unique case (state_q)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = opcode;
          imm_d   = operand;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        dst_d    = (ir_q == OP_LDI) ? '0 : imm_q[3:2];
        src_d    = imm_q[1:0];
        alu_op_d = ir_q;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        take_d  = ((ir_q == OP_JZ) && flag_z) || ((ir_q == OP_JC) && flag_c);
        state_d = ST_WB;
      end
      ST_WB: begin
        acc_we  = writes_acc(ir_q);
        pc_step = 1'b1;
        if ((ir_q == OP_JMP) || take_q) begin
          pc_mode = PC_JUMP;
        end else if (ir_q == RETI_OP) begin
          pc_mode  = PC_RETI;
          in_isr_d = 1'b0;
        end else if (ir_q == HALT_OP) begin
          pc_mode = PC_HOLD;
        end
        // irq_take looks at the pre-RETI in_isr, so a coincident irq waits for the next WB.
        if (irq_take) begin
          pc_irq   = 1'b1;
          irq_ack  = 1'b1;
          in_isr_d = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = (ir_q == HALT_OP) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (irq_take) begin
          pc_step  = 1'b1;
          pc_irq   = 1'b1;
          irq_ack  = 1'b1;
          in_isr_d = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (rst) begin
      instr_ready = 1'b0;
      acc_we      = 1'b0;
      irq_ack     = 1'b0;
      pc_step     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= 4'h0;
      imm_q    <= 4'h0;
      alu_op_q <= 4'h0;
      dst_q    <= '0;
      src_q    <= '0;
      take_q   <= 1'b0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      alu_op_q <= alu_op_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      take_q   <= take_d;
      in_isr_q <= in_isr_d;
    end
  end

  fourbit_pc_unit #(
    .IRQ_VECTOR(IRQ_VECTOR)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .step_en    (pc_step),
    .mode       (pc_mode),
    .jump_target(imm_q),
    .irq_take   (pc_irq),
    .pc         (pc),
    .shadow_pc  (shadow_pc)
  );

  assign ir      = ir_q;
  assign imm     = imm_q;
  assign alu_op  = alu_op_q;
  assign dst_sel = dst_q;
  assign src_sel = src_q;
  assign in_isr  = in_isr_q;
  assign halted  = (state_q == ST_HALT);

endmodule
